// File: rtl/cl_irq_event_queue_if.sv
// ---------------------------------------------------------------------------
// cl_irq_event_queue_if
// Event record handshake between the interrupt event queue (master) and the
// host-side interrupt transactor that drains it (slave).
//   evt_valid  : head record available
//   evt_ready  : consumer accepts the head record
//   evt_vector : full interrupt vector captured with the event
//   evt_edges  : masked bits that changed
//   evt_ts     : timestamp of the event
// ---------------------------------------------------------------------------
interface cl_irq_event_queue_if #(
    parameter int IRQ_W = 32,
    parameter int TS_W  = 32
);
    logic             evt_valid;
    logic             evt_ready;
    logic [IRQ_W-1:0] evt_vector;
    logic [IRQ_W-1:0] evt_edges;
    logic [TS_W-1:0]  evt_ts;

    modport master (
        output evt_valid,
        output evt_vector,
        output evt_edges,
        output evt_ts,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_vector,
        input  evt_edges,
        input  evt_ts,
        output evt_ready
    );
endinterface

// File: rtl/cl_irq_event_queue.sv
// ---------------------------------------------------------------------------
// cl_irq_event_queue
// Watches a registered interrupt vector for per-bit level changes, stamps
// each change set with a free-running timestamp and queues the record in a
// first-word-fall-through FIFO drained through a valid/ready handshake.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   irq_in        : interrupt levels, synchronous to clk
//   irq_mask      : 1 = bit participates in change detection
//   evt_if        : record handshake (master side)
//   evt_count     : FIFO occupancy, 0..DEPTH
//   overflow      : sticky, a record was dropped because the FIFO was full
//   overflow_clr  : single-cycle pulse clearing overflow
//   irq_pending   : level to host, mirrors evt_valid
// ---------------------------------------------------------------------------
module cl_irq_event_queue #(
    parameter int IRQ_W = 32,
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IRQ_W-1:0]         irq_in,
    input  logic [IRQ_W-1:0]         irq_mask,
    cl_irq_event_queue_if.master     evt_if,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     overflow_clr,
    output logic                     irq_pending
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    // Control state
    logic [IRQ_W-1:0] irq_q, irq_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    // Record storage, deliberately not reset
    logic [IRQ_W-1:0] vec_mem [DEPTH];
    logic [IRQ_W-1:0] edg_mem [DEPTH];
    logic [TS_W-1:0]  ts_mem  [DEPTH];

    logic [IRQ_W-1:0] chg;
    logic             push;
    logic             pop;
    logic             push_acc;
    logic             empty;
    logic             full;

    always_comb begin
        chg      = (irq_in ^ irq_q) & irq_mask;
        push     = |chg;
        empty    = (wptr_q == rptr_q);
        // Extra pointer MSB distinguishes full from empty when indices match
        full     = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
        pop      = ~empty & evt_if.evt_ready;
        // A same-cycle pop frees the slot a full FIFO needs for the push
        push_acc = push & (~full | pop);

        irq_d    = irq_in;
        ts_d     = ts_q + TS_W'(1);
        wptr_d   = wptr_q + PW'(push_acc);
        rptr_d   = rptr_q + PW'(pop);
        cnt_d    = cnt_q + PW'(push_acc) - PW'(pop);

        // Set wins over clear so a drop coincident with the clear is kept
        ovf_d    = ovf_q;
        if (overflow_clr) begin
            ovf_d = 1'b0;
        end
        if (push & full & ~pop) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q  <= '0;
            ts_q   <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
        end else begin
            irq_q  <= irq_d;
            ts_q   <= ts_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    // When full with a pop, the write lands in the slot being vacated; the
    // head is read combinationally before the edge so nothing is clobbered.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            vec_mem[wptr_q[AW-1:0]] <= irq_in;
            edg_mem[wptr_q[AW-1:0]] <= chg;
            ts_mem[wptr_q[AW-1:0]]  <= ts_q;
        end
    end

    assign evt_if.evt_valid  = ~empty;
    assign evt_if.evt_vector = vec_mem[rptr_q[AW-1:0]];
    assign evt_if.evt_edges  = edg_mem[rptr_q[AW-1:0]];
    assign evt_if.evt_ts     = ts_mem[rptr_q[AW-1:0]];
    assign evt_count         = cnt_q;
    assign overflow          = ovf_q;
    assign irq_pending       = ~empty;

endmodule

// File: tb/tb_cl_irq_event_queue.sv
module tb_cl_irq_event_queue;
    logic        clk;
    logic        rst;
    logic [31:0] irq_in;
    logic [31:0] irq_mask;
    logic [4:0]  evt_count;
    logic        overflow;
    logic        overflow_clr;
    logic        irq_pending;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] ev [0:17];
    logic [31:0] ee [0:17];
    logic [31:0] et [0:17];
    logic [31:0] exp_ts;

    cl_irq_event_queue_if #(.IRQ_W(32), .TS_W(32)) evt_if ();

    cl_irq_event_queue #(.IRQ_W(32), .DEPTH(16), .TS_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .irq_mask     (irq_mask),
        .evt_if       (evt_if),
        .evt_count    (evt_count),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .irq_pending  (irq_pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_head(input string tag, input logic [31:0] v,
                              input logic [31:0] e, input logic [31:0] t);
        check({tag, "_valid"}, 64'(evt_if.evt_valid), 64'd1);
        check({tag, "_vec"},   64'(evt_if.evt_vector), 64'(v));
        check({tag, "_edges"}, 64'(evt_if.evt_edges),  64'(e));
        check({tag, "_ts"},    64'(evt_if.evt_ts),     64'(t));
    endtask

    initial begin
        rst              = 1'b1;
        irq_in           = 32'h0000_0005;
        irq_mask         = 32'hFFFF_FFFF;
        evt_if.evt_ready = 1'b0;
        overflow_clr     = 1'b0;
        step();
        step();
        check("rst_valid", 64'(evt_if.evt_valid), 64'd0);
        check("rst_count", 64'(evt_count), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        check("rst_pending", 64'(irq_pending), 64'd0);

        // Bits already high at release produce an event on edge 1
        rst = 1'b0;
        cyc = 0;
        step();
        check_head("rel", 32'h5, 32'h5, 32'd0);
        check("rel_count", 64'(evt_count), 64'd1);
        check("rel_pending", 64'(irq_pending), 64'd1);

        // Pop and push in the same cycle keep the count at 1
        evt_if.evt_ready = 1'b1;
        irq_in = 32'h0;
        step();
        check("pp_count", 64'(evt_count), 64'd1);
        check_head("pp", 32'h0, 32'h5, 32'd1);
        step();
        evt_if.evt_ready = 1'b0;
        check("pp_drain_count", 64'(evt_count), 64'd0);
        check("pp_drain_valid", 64'(evt_if.evt_valid), 64'd0);

        // Rising and falling edge on bit 3 at ts 10 and 20
        while (cyc < 10) step();
        irq_in = 32'h8;
        step();
        check("b3_cnt1", 64'(evt_count), 64'd1);
        while (cyc < 20) step();
        irq_in = 32'h0;
        step();
        check("b3_cnt2", 64'(evt_count), 64'd2);
        check_head("b3_e1", 32'h8, 32'h8, 32'd10);
        evt_if.evt_ready = 1'b1;
        step();
        check("b3_cnt3", 64'(evt_count), 64'd1);
        check_head("b3_e2", 32'h0, 32'h8, 32'd20);
        step();
        evt_if.evt_ready = 1'b0;
        check("b3_cnt4", 64'(evt_count), 64'd0);
        check("b3_valid", 64'(evt_if.evt_valid), 64'd0);

        // Masked bit 0 toggles never produce events
        irq_mask = 32'hFFFF_FFFE;
        for (int i = 0; i < 5; i++) begin
            irq_in = irq_in ^ 32'h1;
            step();
        end
        check("mask_count", 64'(evt_count), 64'd0);
        irq_in = irq_in ^ 32'h11;
        exp_ts = cyc;
        step();
        check("mask_cnt1", 64'(evt_count), 64'd1);
        check_head("mask", 32'h10, 32'h10, exp_ts);
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        check("mask_drain", 64'(evt_count), 64'd0);
        irq_mask = 32'hFFFF_FFFF;
        irq_in   = 32'h0;
        step();
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        check("mask_clean", 64'(evt_count), 64'd0);

        // Overflow: 18 changes into a 16-deep FIFO
        for (int i = 0; i < 18; i++) begin
            irq_in = irq_in ^ (32'h1 << i);
            ev[i] = irq_in;
            ee[i] = 32'h1 << i;
            et[i] = cyc;
            step();
        end
        check("ovf_count", 64'(evt_count), 64'd16);
        check("ovf_flag", 64'(overflow), 64'd1);
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check_head("ovf_drain", ev[i], ee[i], et[i]);
            step();
        end
        evt_if.evt_ready = 1'b0;
        check("ovf_empty", 64'(evt_if.evt_valid), 64'd0);
        check("ovf_sticky", 64'(overflow), 64'd1);
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("ovf_clr", 64'(overflow), 64'd0);

        // Full FIFO: push with pop is accepted, no overflow
        for (int i = 0; i < 16; i++) begin
            irq_in = irq_in ^ (32'h1 << i);
            step();
        end
        check("full_count", 64'(evt_count), 64'd16);
        check("full_ovf0", 64'(overflow), 64'd0);
        irq_in = irq_in ^ 32'h0010_0000;
        evt_if.evt_ready = 1'b1;
        step();
        evt_if.evt_ready = 1'b0;
        check("full_pp_count", 64'(evt_count), 64'd16);
        check("full_pp_ovf", 64'(overflow), 64'd0);
        check("full_pp_head", 64'(evt_if.evt_edges), 64'h2);
        // Dropped push beats a coincident clear
        irq_in = irq_in ^ 32'h0020_0000;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        check("setclr_ovf", 64'(overflow), 64'd1);
        check("setclr_count", 64'(evt_count), 64'd16);

        // Leave 5 entries, then reset mid-operation
        evt_if.evt_ready = 1'b1;
        for (int i = 0; i < 11; i++) step();
        evt_if.evt_ready = 1'b0;
        check("pre_rst_count", 64'(evt_count), 64'd5);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(evt_if.evt_valid), 64'd0);
        check("mid_rst_count", 64'(evt_count), 64'd0);
        check("mid_rst_ovf", 64'(overflow), 64'd0);
        irq_in = 32'h4;
        step();
        rst = 1'b0;
        cyc = 0;
        step();
        check_head("post_rst", 32'h4, 32'h4, 32'd0);
        check("post_rst_count", 64'(evt_count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
